// File: rtl/ctrl_pkg.sv
// Shared decode types for the fetch/decode/execute path: opcodes, ALU operations,
// the control-word layout and the accumulator state names.
package ctrl_pkg;

  localparam logic RUN = 1'b0;
  localparam logic PUT = 1'b1;

  typedef enum logic [4:0] {
    OP_LDI  = 5'h00, OP_LOAD = 5'h01, OP_STORE = 5'h02, OP_ADD  = 5'h03,
    OP_SUB  = 5'h04, OP_XOR  = 5'h05, OP_OR    = 5'h06, OP_AND  = 5'h07,
    OP_JUMP = 5'h08, OP_BEQ  = 5'h09, OP_BLT   = 5'h0A, OP_BGT  = 5'h0B,
    OP_SHL  = 5'h0C, OP_SHR  = 5'h0D, OP_USUB  = 5'h0E, OP_SLT  = 5'h0F,
    OP_SGT  = 5'h10, OP_UADD = 5'h11
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_AND  = 4'h0, ALU_XOR  = 4'h1, ALU_OR   = 4'h2, ALU_SHL  = 4'h3,
    ALU_SHR  = 4'h4, ALU_ADD  = 4'h5, ALU_SUB  = 4'h6, ALU_BLT  = 4'h7,
    ALU_BGT  = 4'h8, ALU_BEQ  = 4'h9, ALU_USUB = 4'hA, ALU_SLT  = 4'hB,
    ALU_SGT  = 4'hC, ALU_UADD = 4'hD, ALU_NOP  = 4'hF
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_write;
    logic    branch;
    logic    imm_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = '{alu_op: ALU_NOP, reg_write: 1'b1, mem_to_reg: 1'b0,
                                     mem_write: 1'b0, branch: 1'b0, imm_to_reg: 1'b0};
  localparam ctrl_t CTRL_RESET   = '{alu_op: ALU_NOP, reg_write: 1'b0, mem_to_reg: 1'b0,
                                     mem_write: 1'b0, branch: 1'b0, imm_to_reg: 1'b0};

  typedef enum logic [1:0] {ACC_EMPTY = 2'd0, ACC_ACCUM = 2'd1, ACC_FULL = 2'd2} acc_state_e;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode decoder; shared with the disassembler/trace monitor.
module op_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  output ctrl_t          ctrl,
  output logic           illegal
);

  // Opcode to control-word map; out-of-range opcodes still issue as a non-writing NOP.
  always_comb begin
    ctrl    = CTRL_DEFAULT;
    illegal = 1'b0;
    if (opcode > OPW'(5'h11)) begin
      illegal        = 1'b1;
      ctrl.reg_write = 1'b0;
    end else begin
      case (opcode_e'(opcode[4:0]))
        OP_LDI:   ctrl.imm_to_reg = 1'b1;
        OP_LOAD:  ctrl.mem_to_reg = 1'b1;
        OP_STORE: begin ctrl.mem_write = 1'b1; ctrl.reg_write = 1'b0; end
        OP_ADD:   ctrl.alu_op = ALU_ADD;
        OP_SUB:   ctrl.alu_op = ALU_SUB;
        OP_XOR:   ctrl.alu_op = ALU_XOR;
        OP_OR:    ctrl.alu_op = ALU_OR;
        OP_AND:   ctrl.alu_op = ALU_AND;
        OP_JUMP:  begin ctrl.branch = 1'b1; ctrl.reg_write = 1'b0; end
        OP_BEQ:   begin ctrl.alu_op = ALU_BEQ; ctrl.reg_write = 1'b0; end
        OP_BLT:   begin ctrl.alu_op = ALU_BLT; ctrl.reg_write = 1'b0; end
        OP_BGT:   begin ctrl.alu_op = ALU_BGT; ctrl.reg_write = 1'b0; end
        OP_SHL:   ctrl.alu_op = ALU_SHL;
        OP_SHR:   ctrl.alu_op = ALU_SHR;
        OP_USUB:  ctrl.alu_op = ALU_USUB;
        OP_SLT:   begin ctrl.alu_op = ALU_SLT; ctrl.reg_write = 1'b0; end
        OP_SGT:   begin ctrl.alu_op = ALU_SGT; ctrl.reg_write = 1'b0; end
        OP_UADD:  ctrl.alu_op = ALU_UADD;
        default:  ctrl = CTRL_DEFAULT;
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready handshake, put-immediate accumulator and
// output register feeding execute.
module decode_stage
  import ctrl_pkg::*;
#(
  parameter int IW        = 9,
  parameter int OPW       = 5,
  parameter int VW        = 8,
  parameter int PUT_SLOTS = 2,
  parameter int PCW       = 12
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IW-1:0]                    in_instr,
  input  logic [PCW-1:0]                   in_pc,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output ctrl_t                            out_ctrl,
  output logic [VW*PUT_SLOTS-1:0]          out_imm,
  output logic [PCW-1:0]                   out_pc,
  output logic                             out_illegal,
  output logic [$clog2(PUT_SLOTS+1)-1:0]   put_cnt,
  output logic                             put_ovf
);

  localparam int IMMW = VW * PUT_SLOTS;
  localparam int CW   = $clog2(PUT_SLOTS + 1);

  ctrl_t          dec_ctrl;
  logic           dec_illegal;
  logic           accept;
  logic           is_put;
  acc_state_e     acc_state;
  logic [IMMW-1:0] acc, acc_next;
  logic [CW-1:0]  put_cnt_next;
  logic           put_ovf_next;
  logic           out_valid_next;
  ctrl_t          out_ctrl_next;
  logic [IMMW-1:0] out_imm_next;
  logic [PCW-1:0] out_pc_next;
  logic           out_illegal_next;

  op_decode #(.OPW(OPW)) u_op_decode (
    .opcode  (in_instr[OPW:1]),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_put   = (in_instr[0] == PUT);

  // Accumulator state is a view of put_cnt rather than a separate register.
  always_comb begin
    if (put_cnt == '0) begin
      acc_state = ACC_EMPTY;
    end else if (put_cnt == CW'(PUT_SLOTS)) begin
      acc_state = ACC_FULL;
    end else begin
      acc_state = ACC_ACCUM;
    end
  end

  // Next-state: flush dominates, then put/run acceptance layered over the output handoff.
  always_comb begin
    acc_next         = acc;
    put_cnt_next     = put_cnt;
    put_ovf_next     = put_ovf;
    out_valid_next   = out_valid;
    out_ctrl_next    = out_ctrl;
    out_imm_next     = out_imm;
    out_pc_next      = out_pc;
    out_illegal_next = out_illegal;
    if (flush) begin
      out_valid_next = 1'b0;
      acc_next       = '0;
      put_cnt_next   = '0;
      put_ovf_next   = 1'b0;
    end else begin
      out_valid_next = out_valid && !out_ready;
      if (accept && is_put) begin
        acc_next = (acc << VW) | IMMW'(in_instr[VW:1]);
        case (acc_state)
          ACC_FULL: put_ovf_next = 1'b1;
          default:  put_cnt_next = put_cnt + CW'(1);
        endcase
      end else if (accept) begin
        out_valid_next   = 1'b1;
        out_ctrl_next    = dec_ctrl;
        out_imm_next     = acc;
        out_pc_next      = in_pc;
        out_illegal_next = dec_illegal;
        acc_next         = '0;
        put_cnt_next     = '0;
      end else begin
        acc_next = acc;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      put_cnt     <= '0;
      put_ovf     <= 1'b0;
      out_valid   <= 1'b0;
      out_ctrl    <= CTRL_RESET;
      out_imm     <= '0;
      out_pc      <= '0;
      out_illegal <= 1'b0;
    end else begin
      acc         <= acc_next;
      put_cnt     <= put_cnt_next;
      put_ovf     <= put_ovf_next;
      out_valid   <= out_valid_next;
      out_ctrl    <= out_ctrl_next;
      out_imm     <= out_imm_next;
      out_pc      <= out_pc_next;
      out_illegal <= out_illegal_next;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  in_instr = 9'h000;
  logic [11:0] in_pc = 12'h000;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  ctrl_pkg::ctrl_t out_ctrl;
  logic [15:0] out_imm;
  logic [11:0] out_pc;
  logic        out_illegal;
  logic [1:0]  put_cnt;
  logic        put_ovf;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_imm(out_imm), .out_pc(out_pc),
    .out_illegal(out_illegal), .put_cnt(put_cnt), .put_ovf(put_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // Reference model: pending puts held as a byte queue, output beat as plain fields.
  bit          m_valid;
  logic [3:0]  m_alu;
  logic [4:0]  m_fl;   // {reg_write, mem_to_reg, mem_write, branch, imm_to_reg}
  logic [15:0] m_imm;
  logic [11:0] m_pc;
  bit          m_ill;
  bit          m_ovf;
  int          q[$];

  int alu_tab[18] = '{15, 15, 15, 5, 6, 1, 2, 0, 15, 9, 7, 8, 3, 4, 10, 11, 12, 13};
  bit rw_tab[18]  = '{1, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_alu = 4'hF; m_fl = 5'b00000; m_imm = 16'h0000;
    m_pc = 12'h000; m_ill = 1'b0; m_ovf = 1'b0; q.delete();
  endtask

  task automatic model_decode(input int op);
    if (op > 17) begin
      m_alu = 4'hF; m_fl = 5'b00000; m_ill = 1'b1;
    end else begin
      m_alu = 4'(alu_tab[op]);
      m_fl  = {rw_tab[op], op == 1, op == 2, op == 8, op == 0};
      m_ill = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_ctrl", 32'(out_ctrl), 32'({m_alu, m_fl}));
    chk("out_imm", 32'(out_imm), 32'(m_imm));
    chk("out_pc", 32'(out_pc), 32'(m_pc));
    chk("out_illegal", 32'(out_illegal), 32'(m_ill));
    chk("put_cnt", 32'(put_cnt), q.size());
    chk("put_ovf", 32'(put_ovf), 32'(m_ovf));
  endtask

  function automatic logic [8:0] run_i(input int op);
    logic [4:0] o;
    o = op[4:0];
    return {3'b000, o, 1'b0};
  endfunction

  function automatic logic [8:0] put_i(input logic [7:0] b);
    return {b, 1'b1};
  endfunction

  // One cycle: drive at negedge, check in_ready, advance model, check outputs after posedge.
  task automatic step(input bit v, input logic [8:0] ins, input logic [11:0] pc,
                      input bit rdy, input bit fl);
    bit exp_rdy;
    bit took;
    int op;
    logic [31:0] imm;
    @(negedge clk);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
    #1;
    exp_rdy = !fl && (!m_valid || rdy);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    took = v && exp_rdy;
    if (fl) begin
      m_valid = 1'b0; q.delete(); m_ovf = 1'b0;
    end else begin
      if (m_valid && rdy) m_valid = 1'b0;
      if (took && ins[0]) begin
        q.push_back(int'(ins[8:1]));
        if (q.size() > 2) begin
          void'(q.pop_front());
          m_ovf = 1'b1;
        end
      end else if (took) begin
        op = int'(ins[5:1]);
        model_decode(op);
        imm = 32'h0;
        foreach (q[i]) imm = (imm << 8) | 32'(q[i]);
        m_imm = imm[15:0];
        m_pc = pc;
        m_valid = 1'b1;
        q.delete();
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("reset_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    chk("reset_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // add with no pending puts
    step(1'b1, run_i(3), 12'h010, 1'b1, 1'b0);
    chk("add_alu", 32'(out_ctrl.alu_op), 32'h5);
    chk("add_imm", 32'(out_imm), 32'h0);

    // two puts then load-imm
    step(1'b1, put_i(8'h12), 12'h011, 1'b1, 1'b0);
    step(1'b1, put_i(8'h34), 12'h012, 1'b1, 1'b0);
    step(1'b1, run_i(0), 12'h040, 1'b1, 1'b0);
    chk("ldi_imm", 32'(out_imm), 32'h1234);
    chk("ldi_pc", 32'(out_pc), 32'h040);

    // overflow: three puts into two slots
    step(1'b1, put_i(8'hAA), 12'h041, 1'b1, 1'b0);
    step(1'b1, put_i(8'hBB), 12'h042, 1'b1, 1'b0);
    step(1'b1, put_i(8'hCC), 12'h043, 1'b1, 1'b0);
    chk("ovf_flag", 32'(put_ovf), 32'h1);
    step(1'b1, run_i(3), 12'h044, 1'b1, 1'b0);
    chk("ovf_imm", 32'(out_imm), 32'hBBCC);

    // backpressure with beq pending
    step(1'b0, 9'h000, 12'h000, 1'b1, 1'b0);
    step(1'b1, run_i(9), 12'h100, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, put_i(8'h77), 12'h101, 1'b0, 1'b0);
    chk("bp_alu", 32'(out_ctrl.alu_op), 32'h9);
    chk("bp_rw", 32'(out_ctrl.reg_write), 32'h0);
    step(1'b1, run_i(4), 12'h102, 1'b1, 1'b0);
    chk("b2b_alu", 32'(out_ctrl.alu_op), 32'h6);

    // flush with a pending put and a run presented
    step(1'b0, 9'h000, 12'h000, 1'b1, 1'b0);
    step(1'b1, put_i(8'h55), 12'h200, 1'b1, 1'b0);
    step(1'b1, run_i(3), 12'h201, 1'b1, 1'b1);
    chk("flush_valid", 32'(out_valid), 32'h0);
    step(1'b0, 9'h000, 12'h000, 1'b1, 1'b0);

    // illegal opcode
    step(1'b1, run_i(31), 12'h300, 1'b1, 1'b0);
    chk("ill_flag", 32'(out_illegal), 32'h1);
    step(1'b1, put_i(8'h99), 12'h301, 1'b0, 1'b0);
    async_reset();
    step(1'b0, 9'h000, 12'h000, 1'b1, 1'b0);

    // random traffic with one mid-stream reset
    for (int i = 0; i < 600; i++) begin
      logic [8:0] ins;
      if (i == 300) async_reset();
      if ($urandom_range(0, 1) == 0) ins = put_i(8'($urandom));
      else if ($urandom_range(0, 3) == 0) ins = run_i(int'($urandom_range(18, 31)));
      else ins = run_i(int'($urandom_range(0, 17)));
      step($urandom_range(0, 3) != 0, ins, 12'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage between instruction fetch and execute. It decodes run-type instructions into ALU/memory/branch control. It accumulates consecutive put-type immediates into a multi-byte operand, and moves decoded beats with valid/ready handshakes on both sides. A flush input discards in-flight state on taken branches.

## Interface
- IW, default 9: instruction width; bit 0 is the type (0 = run, 1 = put).
- OPW, default 5: opcode width, bits [OPW:1] of a run instruction.
- VW, default 8: put payload width, bits [VW:1] of a put instruction.
- PUT_SLOTS, default 2: maximum number of puts accumulated into one immediate.
- PCW, default 12: program-counter width.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- in_valid  in  1  fetch beat valid.
- in_ready  out  1  stage can accept a beat.
- in_instr  in  IW  instruction.
- in_pc  in  PCW  instruction address.
- flush  in  1  discard the output register and the accumulator.
- out_valid  out  1  decoded beat valid.
- out_ready  in  1  execute accepts the beat.
- out_ctrl  out  ctrl_t  control fields: alu_op[3:0], reg_write, mem_to_reg, mem_write, branch, imm_to_reg.
- out_imm  out  VW*PUT_SLOTS  accumulated immediate.
- out_pc  out  PCW  address of the run instruction.
- out_illegal  out  1  opcode is outside 0x00–0x11.
- put_cnt  out  $clog2(PUT_SLOTS+1)  number of pending puts.
- put_ovf  out  1  sticky: more than PUT_SLOTS consecutive puts seen.

## Operation
- **Accept rule:** a beat is accepted when in_valid && in_ready.
  - in_ready = !flush && (!out_valid || out_ready).
- **Put accepted:**
  - acc <= {acc[VW*(PUT_SLOTS-1)-1:0], payload}.
  - put_cnt increments and saturates at PUT_SLOTS.
  - Any further put sets put_ovf; the oldest byte is shifted out.
  - No output beat is produced.
- **Run accepted:** the output register loads out_ctrl, out_imm = acc, out_pc, out_illegal, and out_valid <= 1. In the same edge, acc and put_cnt clear to 0.
- **Decode map:** identical to the current ISA.
  - 00 load-imm: imm_to_reg.
  - 01 load: mem_to_reg.
  - 02 store: mem_write, no reg_write.
  - 03–07 add, sub, xor, or, and: ALU ops 5, 6, 1, 2, 0.
  - 08 jump: branch, no reg_write.
  - 09/0A/0B beq/blt/bgt: ALU ops 9, 7, 8, no reg_write.
  - 0C/0D shl/shr: ALU ops 3, 4.
  - 0E usub: ALU op A.
  - 0F/10 signed lt/gt: ALU ops B, C, no reg_write.
  - 11 uadd: ALU op D.
  - Default fields (applied before any opcode-specific field): alu_op 4'hF, reg_write 1, all other flags 0.
- **Illegal opcode:** alu_op = 4'hF, reg_write = 0, out_illegal = 1. The beat is still issued.
- **Accumulator FSM** (state derived from put_cnt; no separate state register):
  - EMPTY (put_cnt = 0) → ACCUM on a put.
  - ACCUM (0 < put_cnt < PUT_SLOTS) → FULL when put_cnt reaches PUT_SLOTS.
  - Any state → EMPTY on a run or flush.
  - FULL + put → FULL, with put_ovf set.
- **Flush:**
  - Clears out_valid, acc, put_cnt and put_ovf.
  - Takes priority over any accept and any output handoff in the same cycle.
  - The input beat presented during flush is not accepted (in_ready = 0).
- **Backpressure:** while out_valid && !out_ready, all outputs hold stable and puts are not accepted.

## Timing
- **Latency:** a run instruction accepted at edge N appears on out_* after edge N and is valid from then on.
- **Throughput:** one run per cycle at full throughput; puts consume one cycle each.
- **Output handoff:** the output register empties on out_valid && out_ready unless a new run is accepted in the same edge. In that case it reloads with the new beat and out_valid stays 1.
- **Reset values:**
  - out_valid 0, put_cnt 0, put_ovf 0, out_illegal 0.
  - out_ctrl: alu_op 4'hF, all flags 0.
  - out_imm 0, out_pc 0; acc 0.
  - in_ready is 1 after reset (flush deasserted).
- **Reset mid-operation:** pending puts and an unconsumed output beat are lost. No beat is issued after reset until a new run is accepted.

## Structure
- **Package ctrl_pkg:**
  - opcode_e enum (0x00–0x11).
  - alu_op_e enum (4'h0–4'hD, NOP = 4'hF).
  - ctrl_t packed struct.
  - Type-bit constants RUN = 0, PUT = 1.
- **Sub-module op_decode:** purely combinational opcode → {ctrl_t, illegal}. It is reused by the disassembler/trace monitor.
- **decode_stage itself:** the handshake, the accumulator and the output register.

## Test plan
- Reset, then run add (opcode 03) with no puts → 1 cycle later out_valid = 1, alu_op = 5, reg_write = 1, out_imm = 0.
- put 0x12, put 0x34, run load-imm at pc 0x040 → out_imm = 0x1234, imm_to_reg = 1, out_pc = 0x040, put_cnt returns to 0.
- puts 0xAA, 0xBB, 0xCC with PUT_SLOTS = 2 → put_ovf = 1, next run gives out_imm = 0xBBCC.
- Hold out_ready = 0 for 3 cycles with a beq pending → outputs stable, in_ready = 0, a following put is not accepted; release → beq (alu_op 9, reg_write 0) handed off, next beat issued back-to-back.
- flush asserted together with in_valid (run) and one pending put → out_valid = 0 and put_cnt = 0 next cycle, the input beat is not consumed.
- Opcode 0x1F → out_illegal = 1, alu_op = 4'hF, reg_write = 0; assert rst_n low mid-stream → all outputs at reset values asynchronously.
